beep_tone_driver: RTL and testbench

//  Consumer end of the beeper request interface. Takes the level requests

---
 rtl/beep_tone_driver.sv | 116 +++++++++++
 tb/tb_beep_tone_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/beep_tone_driver.sv
// Buzzer burst generator: edge-triggered low/high tone square-wave bursts.
// Optional BEEP_MUTE_EN adds a 'mute' input that silences the buzzer pin only.
module beep_tone_driver #(
  parameter int HALF_P_LO = 97656,
  parameter int HALF_P_HI = 50000,
  parameter int DUR_LO    = 10000000,
  parameter int DUR_HI    = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic beep512Hz,
  input  logic beep1kHz,
`ifdef BEEP_MUTE_EN
  input  logic mute,
`endif
  output logic buzzer,
  output logic busy,
  output logic tone_hi,
  output logic done
);

  localparam int MAX_D = (DUR_LO > DUR_HI) ? DUR_LO : DUR_HI;
  localparam int MAX_H = (HALF_P_LO > HALF_P_HI) ? HALF_P_LO : HALF_P_HI;
  localparam int MAX_V = (MAX_D > MAX_H) ? MAX_D : MAX_H;
  localparam int CW    = (MAX_V > 1) ? $clog2(MAX_V) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TONE_LO,
    TONE_HI
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [CW-1:0] half_end, dur_end;
  logic          tone_q, tone_d;
  logic          done_q, done_d;
  logic          lo_q, hi_q;
  logic          rise_lo, rise_hi;

  assign rise_lo = beep512Hz & ~lo_q;
  assign rise_hi = beep1kHz & ~hi_q;

  assign half_end = (state_q == TONE_HI) ? CW'(HALF_P_HI - 1)
                                         : CW'(HALF_P_LO - 1);
  assign dur_end  = (state_q == TONE_HI) ? CW'(DUR_HI - 1)
                                         : CW'(DUR_LO - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      dur_q   <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      lo_q    <= beep512Hz;
      hi_q    <= beep1kHz;
    end
  end

  // A new start always wins over ending, so no done on an overlapping rise
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    if (rise_hi) begin
      state_d = TONE_HI;
      phase_d = '0;
      dur_d   = '0;
      tone_d  = 1'b1;
    end else if (rise_lo && state_q != TONE_HI) begin
      state_d = TONE_LO;
      phase_d = '0;
      dur_d   = '0;
      tone_d  = 1'b1;
    end else if (state_q != IDLE) begin
      if (dur_q == dur_end) begin
        state_d = IDLE;
        phase_d = '0;
        dur_d   = '0;
        tone_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        dur_d = dur_q + 1'b1;
        if (phase_q == half_end) begin
          phase_d = '0;
          tone_d  = ~tone_q;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign tone_hi = (state_q == TONE_HI);
  assign done    = done_q;

`ifdef BEEP_MUTE_EN
  assign buzzer = tone_q & ~mute;
`else
  assign buzzer = tone_q;
`endif

endmodule

// File: tb/tb_beep_tone_driver.sv
// Directed table-driven bench for beep_tone_driver.
// Small parameters: HALF_P_LO=4, HALF_P_HI=2, DUR_LO=20, DUR_HI=12.
module tb_beep_tone_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_lo = 1'b0;
  logic b_hi = 1'b0;
  logic mute = 1'b0;
  logic buzzer, busy, tone_hi, done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  beep_tone_driver #(
    .HALF_P_LO(4),
    .HALF_P_HI(2),
    .DUR_LO(20),
    .DUR_HI(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .beep512Hz(b_lo),
    .beep1kHz(b_hi),
`ifdef BEEP_MUTE_EN
    .mute(mute),
`endif
    .buzzer(buzzer),
    .busy(busy),
    .tone_hi(tone_hi),
    .done(done)
  );

  // exp = {buzzer, busy, tone_hi, done}, checked after the edge
  typedef struct {
    string      tag;
    logic       rst;
    logic       lo;
    logic       hi;
    logic       mute;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] e(bit bz, bit by, bit th, bit dn);
    return {bz, by, th, dn};
  endfunction

  function void add(string tag, logic r, logic lo, logic hi,
                    logic m, logic [3:0] ex);
    vec_t v;
    v.tag = tag; v.rst = r; v.lo = lo; v.hi = hi;
    v.mute = m; v.exp = ex;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] got;
    int n;
    int nbusy;
    bit seen;

    // reset and idle
    add("reset", 1, 0, 0, 0, e(0,0,0,0));
    add("reset", 1, 1, 0, 0, e(0,0,0,0));
    add("idle",  0, 0, 0, 0, e(0,0,0,0));
    // 1: low burst, held request
    for (int i = 0; i < 20; i++)
      add("t1_lo", 0, 1, 0, 0, e((i % 8) < 4, 1, 0, 0));
    add("t1_done", 0, 1, 0, 0, e(0,0,0,1));
    for (int i = 0; i < 3; i++)
      add("t1_held", 0, 1, 0, 0, e(0,0,0,0));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    // 2: both rise together
    for (int i = 0; i < 12; i++)
      add("t2_hi", 0, 1, 1, 0, e((i % 4) < 2, 1, 1, 0));
    add("t2_done", 0, 1, 1, 0, e(0,0,0,1));
    add("t2_held", 0, 1, 1, 0, e(0,0,0,0));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    // 3: high preempts low on the 7th edge
    for (int i = 0; i < 6; i++)
      add("t3_lo", 0, 1, 0, 0, e((i % 8) < 4, 1, 0, 0));
    for (int i = 0; i < 12; i++)
      add("t3_hi", 0, 1, 1, 0, e((i % 4) < 2, 1, 1, 0));
    add("t3_done", 0, 1, 1, 0, e(0,0,0,1));
    add("t3_after", 0, 1, 1, 0, e(0,0,0,0));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    // 4: low ignored during high; high retriggers at 9th edge
    for (int i = 0; i < 8; i++)
      add("t4_hi", 0, (i >= 3), (i < 6), 0, e((i % 4) < 2, 1, 1, 0));
    for (int i = 0; i < 12; i++)
      add("t4_retrig", 0, 1, 1, 0, e((i % 4) < 2, 1, 1, 0));
    add("t4_done", 0, 1, 1, 0, e(0,0,0,1));
    add("t4_after", 0, 1, 1, 0, e(0,0,0,0));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    // 5: reset mid-burst, level held through reset
    for (int i = 0; i < 5; i++)
      add("t5_hi", 0, 0, 1, 0, e((i % 4) < 2, 1, 1, 0));
    add("t5_rst", 1, 0, 1, 0, e(0,0,0,0));
    add("t5_rst", 1, 0, 1, 0, e(0,0,0,0));
    for (int i = 0; i < 12; i++)
      add("t5_hi2", 0, 0, 1, 0, e((i % 4) < 2, 1, 1, 0));
    add("t5_done", 0, 0, 1, 0, e(0,0,0,1));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    // rise on the very edge a low burst ends: restart, no done
    for (int i = 0; i < 20; i++)
      add("end_lo", 0, (i != 19), 0, 0, e((i % 8) < 4, 1, 0, 0));
    for (int i = 0; i < 20; i++)
      add("end_re", 0, 1, 0, 0, e((i % 8) < 4, 1, 0, 0));
    add("end_done", 0, 1, 0, 0, e(0,0,0,1));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
`ifdef BEEP_MUTE_EN
    // 6: muted low burst, then unmute mid-burst
    for (int i = 0; i < 20; i++)
      add("t6_mute", 0, 1, 0, 1, e(0, 1, 0, 0));
    add("t6_done", 0, 1, 0, 1, e(0,0,0,1));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
    for (int i = 0; i < 20; i++)
      add("t6_unmute", 0, 1, 0, (i < 10),
          e((i >= 10) && ((i % 8) < 4), 1, 0, 0));
    add("t6_done2", 0, 1, 0, 0, e(0,0,0,1));
    add("idle", 0, 0, 0, 0, e(0,0,0,0));
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      b_lo = tbl[i].lo;
      b_hi = tbl[i].hi;
      mute = tbl[i].mute;
      @(posedge clk);
      #1;
      got = {buzzer, busy, tone_hi, done};
      n_chk++;
      if (got !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL %s row %0d: got bz/busy/hi/done=%b required %b",
                 tbl[i].tag, i, got, tbl[i].exp);
      end
    end

    // hand-written: bounded wait for done after a fresh high request
    @(negedge clk);
    b_lo = 0; b_hi = 0; mute = 0;
    @(negedge clk);
    b_hi = 1;
    n = 0; nbusy = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) nbusy++;
      if (done) seen = 1;
    end
    n_chk++;
    if (!seen || n != 13) begin
      n_fail++;
      $display("FAIL wait_done: got done at edge %0d (seen=%0d) required 13",
               n, seen);
    end
    n_chk++;
    if (nbusy != 12) begin
      n_fail++;
      $display("FAIL busy_len: got %0d busy cycles required 12", nbusy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
